// File: rtl/packet_source_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : packet_source_pkg
//  Brief    : Shared types and constants for the packet_source traffic generator.
//  Revision : 1.0 - initial release
// ============================================================================
package packet_source_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_BODY = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int DEST_BITS_DEFAULT = 8;
    localparam int PKT_COUNT_W       = 16;

    // Right-shifting Galois feedback masks, indexed by register width.
    function automatic logic [31:0] lfsr_taps(input int size);
        logic [31:0] taps;
        case (size)
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_00B8;
        endcase
        return taps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_source_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : packet_source_lfsr
//  Brief    : Galois LFSR payload generator, seeded all-ones; only compiled
//             when PACKET_SOURCE_LFSR_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef PACKET_SOURCE_LFSR_EN
module packet_source_lfsr #(
    parameter int              SIZE = 8,
    parameter logic [SIZE-1:0] TAPS = 8'hB8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    output logic [SIZE-1:0] value
);

    logic [SIZE-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '1;
        end else if (advance) begin
            r_value <= r_value[0] ? ((r_value >> 1) ^ TAPS) : (r_value >> 1);
        end
    end

    assign value = r_value;

endmodule
`endif
`default_nettype wire

// File: rtl/packet_source.sv
`default_nettype none
// ============================================================================
//  Module   : packet_source
//  Brief    : NoC injection traffic generator driving fixed-length packets
//             onto a req/ack channel. Define PACKET_SOURCE_LFSR_EN for LFSR
//             payload words instead of the incrementing sequence counter.
//  Revision : 1.0 - initial release
// ============================================================================
module packet_source
    import packet_source_pkg::*;
#(
    parameter int ID        = 0,
    parameter int SIZE      = 8,
    parameter int DEST_BITS = DEST_BITS_DEFAULT,
    parameter int DEST      = 0,
    parameter int PKT_FLITS = 4,
    parameter int GAP       = 2,
    parameter int MAX_PKTS  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   ch_req,
    output logic [SIZE-1:0]        ch_flit,
    input  logic                   ch_ack,
    output logic [PKT_COUNT_W-1:0] pkt_count,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = $clog2(PKT_FLITS);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [DEST_BITS-1:0]   c_dest     = DEST_BITS'(DEST);
    localparam logic [SIZE-1:0]        c_head     = SIZE'(c_dest);
    localparam logic [SIZE-1:0]        c_id       = SIZE'(ID);
    localparam logic [IDX_W-1:0]       c_last_idx = IDX_W'(PKT_FLITS - 1);
    localparam logic [PKT_COUNT_W-1:0] c_max      = PKT_COUNT_W'(MAX_PKTS);
    localparam logic [GAP_W-1:0]       c_gap_load = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_ch_req;
    logic [SIZE-1:0]        r_ch_flit;
    logic [PKT_COUNT_W-1:0] r_pkt_count;
    logic                   r_done;
    logic [GAP_W-1:0]       r_gap_cnt;

    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic                   w_req_nxt;
    logic [SIZE-1:0]        w_flit_nxt;
    logic [PKT_COUNT_W-1:0] w_cnt_nxt;
    logic                   w_done_nxt;
    logic [GAP_W-1:0]       w_gap_nxt;
    logic                   w_payload_adv;
    logic [SIZE-1:0]        w_payload;
    logic [PKT_COUNT_W-1:0] w_cnt_inc;
    logic                   w_xfer;

    assign w_xfer    = r_ch_req & ch_ack;
    assign w_cnt_inc = r_pkt_count + PKT_COUNT_W'(1);

`ifdef PACKET_SOURCE_LFSR_EN
    localparam logic [31:0] c_taps_full = lfsr_taps(SIZE);

    packet_source_lfsr #(
        .SIZE (SIZE),
        .TAPS (c_taps_full[SIZE-1:0])
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_payload_adv),
        .value   (w_payload)
    );
`else
    logic [SIZE-1:0] r_seq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq <= '0;
        end else if (w_payload_adv) begin
            r_seq <= r_seq + SIZE'(1);
        end
    end

    assign w_payload = r_seq;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_ch_req    <= 1'b0;
            r_ch_flit   <= '0;
            r_pkt_count <= '0;
            r_done      <= 1'b0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_ch_req    <= w_req_nxt;
            r_ch_flit   <= w_flit_nxt;
            r_pkt_count <= w_cnt_nxt;
            r_done      <= w_done_nxt;
            r_gap_cnt   <= w_gap_nxt;
        end
    end

    // Outputs are registered: the flit for the next beat is loaded on the
    // edge that accepts the current one, so a held ack gives one flit per cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_req_nxt     = r_ch_req;
        w_flit_nxt    = r_ch_flit;
        w_cnt_nxt     = r_pkt_count;
        w_done_nxt    = r_done;
        w_gap_nxt     = r_gap_cnt;
        w_payload_adv = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable && !r_done) begin
                    w_state_nxt = ST_HEAD;
                    w_req_nxt   = 1'b1;
                    w_flit_nxt  = c_head;
                end
            end

            ST_HEAD: begin
                if (w_xfer) begin
                    w_state_nxt = ST_BODY;
                    w_idx_nxt   = IDX_W'(1);
                    w_flit_nxt  = c_id;
                end
            end

            ST_BODY: begin
                if (w_xfer) begin
                    if (r_idx == c_last_idx) begin
                        w_cnt_nxt = w_cnt_inc;
                        w_req_nxt = 1'b0;
                        if (MAX_PKTS != 0 && w_cnt_inc == c_max) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                            w_flit_nxt  = '0;
                        end else if (GAP > 0) begin
                            w_state_nxt = ST_GAP;
                            w_gap_nxt   = c_gap_load;
                        end else if (enable) begin
                            w_state_nxt = ST_HEAD;
                            w_req_nxt   = 1'b1;
                            w_flit_nxt  = c_head;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_idx_nxt     = r_idx + IDX_W'(1);
                        w_flit_nxt    = w_payload;
                        w_payload_adv = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    if (enable) begin
                        w_state_nxt = ST_HEAD;
                        w_req_nxt   = 1'b1;
                        w_flit_nxt  = c_head;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt - GAP_W'(1);
                end
            end

            ST_DONE: begin
                w_req_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    assign ch_req    = r_ch_req;
    assign ch_flit   = r_ch_flit;
    assign pkt_count = r_pkt_count;
    assign done      = r_done;
    assign busy      = (r_state == ST_HEAD) || (r_state == ST_BODY);

endmodule
`default_nettype wire

// File: tb/tb_packet_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_packet_source
//  Brief    : Directed self-checking bench for packet_source (default instance
//             plus a GAP=0 / MAX_PKTS=3 instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_packet_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        en0, ack0, en1, ack1;
    logic        req0, busy0, done0, req1, busy1, done1;
    logic [7:0]  flit0, flit1;
    logic [15:0] cnt0, cnt1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    packet_source u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .enable    (en0),
        .ch_req    (req0),
        .ch_flit   (flit0),
        .ch_ack    (ack0),
        .pkt_count (cnt0),
        .busy      (busy0),
        .done      (done0)
    );

    packet_source #(
        .ID        (3),
        .DEST      (8'h5A),
        .PKT_FLITS (3),
        .GAP       (0),
        .MAX_PKTS  (3)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .enable    (en1),
        .ch_req    (req1),
        .ch_flit   (flit1),
        .ch_ack    (ack1),
        .pkt_count (cnt1),
        .busy      (busy1),
        .done      (done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n-th payload word after reset.
    function automatic logic [7:0] payload(input int n);
`ifdef PACKET_SOURCE_LFSR_EN
        logic [7:0] x;
        x = 8'hFF;
        for (int i = 0; i < n; i++) begin
            x = x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
        end
        return x;
`else
        return 8'(n);
`endif
    endfunction

    int         e_req0 [13];
    int         e_cnt0 [13];
    logic [7:0] e_fl0  [13];
    int         e_req1 [10];
    int         e_cnt1 [10];
    int         e_done1[10];
    logic [7:0] e_fl1  [10];

    initial begin
        reset = 1'b1;
        en0 = 1'b0; ack0 = 1'b0; en1 = 1'b0; ack1 = 1'b0;
        step();
        step();
        chk("rst_req",   req0,  0);
        chk("rst_flit",  flit0, 0);
        chk("rst_cnt",   cnt0,  0);
        chk("rst_busy",  busy0, 0);
        chk("rst_done",  done0, 0);
        chk("rst_req1",  req1,  0);

        // Free-running traffic: head, ID, two payload words, two idle cycles.
        reset = 1'b0; en0 = 1'b1; ack0 = 1'b1;
        e_req0 = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        e_cnt0 = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2};
        e_fl0  = '{8'h00, 8'h00, payload(0), payload(1), 8'h00, 8'h00,
                   8'h00, 8'h00, payload(2), payload(3), 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 13; i++) begin
            step();
            chk($sformatf("run_req[%0d]", i),  req0,  e_req0[i]);
            chk($sformatf("run_busy[%0d]", i), busy0, e_req0[i]);
            chk($sformatf("run_cnt[%0d]", i),  cnt0,  e_cnt0[i]);
            if (e_req0[i] == 1) chk($sformatf("run_flit[%0d]", i), flit0, e_fl0[i]);
        end

        // Back-pressure on a payload flit.
        step();
        chk("bp_id", flit0, 8'h00);
        step();
        chk("bp_pay", flit0, payload(4));
        ack0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold_req[%0d]", i),  req0,  1);
            chk($sformatf("bp_hold_flit[%0d]", i), flit0, payload(4));
        end
        ack0 = 1'b1;
        step();
        chk("bp_tail", flit0, payload(5));
        step();
        chk("bp_tail_req", req0, 0);
        chk("bp_cnt",      cnt0, 3);

        // enable dropped mid-packet: packet completes, then source parks.
        step();
        chk("en_gap_req", req0, 0);
        step();
        chk("en_head_req",  req0,  1);
        chk("en_head_flit", flit0, 8'h00);
        step();
        chk("en_id", flit0, 8'h00);
        step();
        chk("en_pay", flit0, payload(6));
        en0 = 1'b0;
        step();
        chk("en_tail",     flit0, payload(7));
        chk("en_tail_req", req0,  1);
        step();
        chk("en_cnt", cnt0, 4);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("en_park_req[%0d]", i),  req0,  0);
            chk($sformatf("en_park_busy[%0d]", i), busy0, 0);
            step();
        end
        en0 = 1'b1;
        step();
        chk("en_resume_req",  req0,  1);
        chk("en_resume_flit", flit0, 8'h00);
        step();
        step();
        chk("en_resume_pay", flit0, payload(8));

        // Reset in the middle of a packet.
        reset = 1'b1;
        step();
        chk("mid_rst_req",  req0,  0);
        chk("mid_rst_cnt",  cnt0,  0);
        chk("mid_rst_busy", busy0, 0);
        reset = 1'b0;
        step();
        chk("post_rst_head", req0, 1);
        step();
        step();
        chk("post_rst_pay", flit0, payload(0));
        en0 = 1'b0;

        // GAP=0, 3-flit packets, stop after three packets.
        en1 = 1'b1; ack1 = 1'b1;
        e_req1  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        e_cnt1  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
        e_done1 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        e_fl1   = '{8'h5A, 8'h03, payload(0), 8'h5A, 8'h03, payload(1),
                    8'h5A, 8'h03, payload(2), 8'h00};
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("b2b_req[%0d]", i),  req1,  e_req1[i]);
            chk($sformatf("b2b_busy[%0d]", i), busy1, e_req1[i]);
            chk($sformatf("b2b_cnt[%0d]", i),  cnt1,  e_cnt1[i]);
            chk($sformatf("b2b_done[%0d]", i), done1, e_done1[i]);
            if (e_req1[i] == 1) chk($sformatf("b2b_flit[%0d]", i), flit1, e_fl1[i]);
            if (i == 7) en1 = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            en1 = ~en1;
            step();
            chk($sformatf("done_req[%0d]", i),  req1,  0);
            chk($sformatf("done_done[%0d]", i), done1, 1);
            chk($sformatf("done_cnt[%0d]", i),  cnt1,  3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
